// File: rtl/serial_frame_tx_if.sv
// Load/serial-line bundle between a frame source and serial_frame_tx.
// The master drives the word and load strobe; the slave returns ready, tx and done.
interface serial_frame_tx_if #(
  parameter int DATA_W = 8
);
  logic [DATA_W-1:0] data_in;
  logic              load;
  logic              ready;
  logic              tx;
  logic              done;

  modport master (output data_in, output load, input ready, input tx, input done);
  modport slave  (input data_in, input load, output ready, output tx, output done);
endinterface

// File: rtl/serial_frame_tx.sv
// Parallel-in serial-out frame transmitter: start(0), data LSB first, stop(1).
// Define SERIAL_FRAME_TX_PARITY_EN to insert an even-parity bit before the stop bit.
//
// state    | meaning
// ---------+----------------------------------------------
// S_IDLE   | line high, ready for a load
// S_START  | start bit (tx=0)
// S_DATA   | data bits, shreg[0] on the line
// S_PARITY | even parity of the captured word (option only)
// S_STOP   | stop bit (tx=1), done on its last cycle
module serial_frame_tx #(
  parameter int DATA_W       = 8,
  parameter int CLKS_PER_BIT = 4
) (
  input  logic                clk,
  input  logic                rst,
  serial_frame_tx_if.slave    bus
);

  localparam int TW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam int BW = (DATA_W > 1) ? $clog2(DATA_W) : 1;
  localparam logic [TW-1:0] T_LAST = TW'(CLKS_PER_BIT - 1);
  localparam logic [BW-1:0] B_LAST = BW'(DATA_W - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
`ifdef SERIAL_FRAME_TX_PARITY_EN
    S_PARITY,
`endif
    S_STOP
  } state_t;

  state_t            state_q, state_d;
  logic [TW-1:0]     timer_q, timer_d;
  logic [BW-1:0]     bit_q, bit_d;
  logic [DATA_W-1:0] shreg_q, shreg_d;
  logic              tx_q, tx_d;
  logic              ready_q, ready_d;
  logic              done_q, done_d;
  logic              bit_end;
`ifdef SERIAL_FRAME_TX_PARITY_EN
  logic              parity_q, parity_d;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= S_IDLE;
      timer_q  <= '0;
      bit_q    <= '0;
      shreg_q  <= '0;
      tx_q     <= 1'b1;
      ready_q  <= 1'b1;
      done_q   <= 1'b0;
`ifdef SERIAL_FRAME_TX_PARITY_EN
      parity_q <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      timer_q  <= timer_d;
      bit_q    <= bit_d;
      shreg_q  <= shreg_d;
      tx_q     <= tx_d;
      ready_q  <= ready_d;
      done_q   <= done_d;
`ifdef SERIAL_FRAME_TX_PARITY_EN
      parity_q <= parity_d;
`endif
    end
  end

  always_comb begin
    state_d  = state_q;
    timer_d  = timer_q;
    bit_d    = bit_q;
    shreg_d  = shreg_q;
`ifdef SERIAL_FRAME_TX_PARITY_EN
    parity_d = parity_q;
`endif
    bit_end  = (timer_q == T_LAST);

    case (state_q)
      S_IDLE: begin
        if (bus.load) begin
          shreg_d  = bus.data_in;
          timer_d  = '0;
          bit_d    = '0;
`ifdef SERIAL_FRAME_TX_PARITY_EN
          parity_d = ^bus.data_in;
`endif
          state_d  = S_START;
        end
      end
      S_START: begin
        if (bit_end) begin
          timer_d = '0;
          state_d = S_DATA;
        end else begin
          timer_d = timer_q + TW'(1);
        end
      end
      S_DATA: begin
        if (bit_end) begin
          timer_d = '0;
          shreg_d = shreg_q >> 1;
          if (bit_q == B_LAST) begin
            bit_d = '0;
`ifdef SERIAL_FRAME_TX_PARITY_EN
            state_d = S_PARITY;
`else
            state_d = S_STOP;
`endif
          end else begin
            bit_d = bit_q + BW'(1);
          end
        end else begin
          timer_d = timer_q + TW'(1);
        end
      end
`ifdef SERIAL_FRAME_TX_PARITY_EN
      S_PARITY: begin
        if (bit_end) begin
          timer_d = '0;
          state_d = S_STOP;
        end else begin
          timer_d = timer_q + TW'(1);
        end
      end
`endif
      S_STOP: begin
        if (bit_end) begin
          timer_d = '0;
          state_d = S_IDLE;
        end else begin
          timer_d = timer_q + TW'(1);
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Outputs are decoded from the next state so the registers present them
  // in the same cycle the FSM enters that state.
  always_comb begin
    tx_d    = 1'b1;
    ready_d = (state_d == S_IDLE);
    done_d  = (state_d == S_STOP) && (timer_d == T_LAST);
    case (state_d)
      S_START:  tx_d = 1'b0;
      S_DATA:   tx_d = shreg_d[0];
`ifdef SERIAL_FRAME_TX_PARITY_EN
      S_PARITY: tx_d = parity_q;
`endif
      default:  tx_d = 1'b1;
    endcase
  end

  assign bus.tx    = tx_q;
  assign bus.ready = ready_q;
  assign bus.done  = done_q;

endmodule
